// File: rtl/mem_arb_pkg.sv
// Shared constants for the data RAM port arbiter: funct3 access sizes and FSM state encoding.
package mem_arb_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWaitIf,
        StWaitLs,
        StErrLs
    } arb_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store path: store enables and replicated data, load
// extraction and extension, and misaligned / illegal-size detection.
module lsu_align
    import mem_arb_pkg::*;
(
    input  logic        i_we,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [2:0]  i_ld_size,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_err,
    output logic [31:0] o_ldata
);

    logic        w_illegal;
    logic        w_misalign;
    logic [31:0] w_shift;

    always_comb begin
        o_be       = '0;
        o_wdata    = '0;
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        unique case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                w_misalign = i_addr_lo[0];
            end
            SZ_W: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                w_misalign = |i_addr_lo;
            end
            // Unsigned sizes only make sense for loads.
            SZ_BU: w_illegal = i_we;
            SZ_HU: begin
                w_illegal  = i_we;
                w_misalign = i_addr_lo[0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign o_err   = w_illegal | w_misalign;
    assign w_shift = i_rdata >> {i_ld_addr_lo, 3'b000};

    always_comb begin
        o_ldata = w_shift;
        unique case (i_ld_size)
            SZ_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            SZ_BU:   o_ldata = {24'h0, w_shift[7:0]};
            SZ_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            SZ_HU:   o_ldata = {16'h0, w_shift[15:0]};
            default: o_ldata = w_shift;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data RAM port between instruction fetch and the MEM-stage load/store unit.
// One RAM transaction outstanding at a time; illegal load/stores are answered without the RAM.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [2:0]        ls_size_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [LANES-1:0]  ram_be_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic              ram_gnt_i,
    input  logic              ram_rvalid_i,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    arb_state_e r_state, w_state_nxt;
    logic       r_last_ls, w_last_ls_nxt;
    logic [1:0] r_addr_lo;
    logic [2:0] r_size;
    logic       r_we;

    logic              w_sel_ls;
    logic              w_lat_en;
    logic              w_ram_req;
    logic              w_ls_err;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_wdata;
    logic [31:0]       w_ld_data;
    logic [ADDR_W-3:0] w_word_addr;
    logic              w_unused_if_lo;

    lsu_align u_lsu_align (
        .i_we         (ls_we_i),
        .i_addr_lo    (ls_addr_i[1:0]),
        .i_size       (ls_size_i),
        .i_wdata      (ls_wdata_i),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_size    (r_size),
        .i_rdata      (ram_rdata_i),
        .o_be         (w_st_be),
        .o_wdata      (w_st_wdata),
        .o_err        (w_ls_err),
        .o_ldata      (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_last_ls <= 1'b0;
            r_addr_lo <= '0;
            r_size    <= '0;
            r_we      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_ls <= w_last_ls_nxt;
            if (w_lat_en) begin
                r_addr_lo <= ls_addr_i[1:0];
                r_size    <= ls_size_i;
                r_we      <= ls_we_i & w_sel_ls;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_ls_nxt = r_last_ls;
        w_sel_ls      = 1'b0;
        w_lat_en      = 1'b0;
        w_ram_req     = 1'b0;
        if_gnt_o      = 1'b0;
        ls_gnt_o      = 1'b0;
        if_rvalid_o   = 1'b0;
        ls_rvalid_o   = 1'b0;
        ls_err_o      = 1'b0;
        if_rdata_o    = '0;
        ls_rdata_o    = '0;
        unique case (r_state)
            StIdle: begin
                // A bad LS access is accepted locally and beats a pending fetch.
                if (ls_req_i && w_ls_err) begin
                    ls_gnt_o    = 1'b1;
                    w_state_nxt = StErrLs;
                end else if (ls_req_i || if_req_i) begin
                    w_sel_ls  = ls_req_i && !(if_req_i && r_last_ls);
                    w_ram_req = 1'b1;
                    if (ram_gnt_i) begin
                        ls_gnt_o      = w_sel_ls;
                        if_gnt_o      = !w_sel_ls;
                        w_state_nxt   = w_sel_ls ? StWaitLs : StWaitIf;
                        w_last_ls_nxt = w_sel_ls;
                        w_lat_en      = 1'b1;
                    end
                end
            end
            StWaitIf: begin
                if (ram_rvalid_i) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = ram_rdata_i;
                    w_state_nxt = StIdle;
                end
            end
            StWaitLs: begin
                if (ram_rvalid_i) begin
                    ls_rvalid_o = 1'b1;
                    ls_rdata_o  = r_we ? '0 : w_ld_data;
                    w_state_nxt = StIdle;
                end
            end
            StErrLs: begin
                ls_rvalid_o = 1'b1;
                ls_err_o    = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_word_addr    = w_sel_ls ? ls_addr_i[ADDR_W-1:2] : if_addr_i[ADDR_W-1:2];
    assign w_unused_if_lo = ^if_addr_i[1:0];

    assign ram_req_o   = w_ram_req;
    assign ram_we_o    = w_ram_req & w_sel_ls & ls_we_i;
    assign ram_addr_o  = w_ram_req ? {w_word_addr, 2'b00} : '0;
    assign ram_be_o    = !w_ram_req ? 4'b0000 : (ram_we_o ? w_st_be : 4'b1111);
    assign ram_wdata_o = ram_we_o ? w_st_wdata : '0;

endmodule
